// File: rtl/branch_dir_predictor.sv
// Dynamic branch-direction predictor: a table of 2-bit saturating counters read in D,
// resolved and trained in E, with saturating branch/mispredict statistics.
module branch_dir_predictor #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_D,
  input  logic        valid_D,
  input  logic [3:0]  br_type_D,
  input  logic        stall,
  input  logic        flush,
  input  logic        comp_result_E,
  output logic        pred_valid_D,
  output logic        pred_taken_D,
  output logic        mispredict_E,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       cnt_table [ENTRIES];
  logic [IDX_W-1:0] idx_D;
  logic             br_valid_E;
  logic             pred_E;
  logic [IDX_W-1:0] idx_E;
  logic [1:0]       cur_cnt;
  logic [1:0]       next_cnt;
  logic             train;
  logic             raw_mispredict;
  logic [31:0]      br_count_q;
  logic [31:0]      miss_count_q;
  logic             unused_pc_bits;

  assign idx_D          = pc_D[IDX_W+1:2];
  assign unused_pc_bits = ^{pc_D[31:IDX_W+2], pc_D[1:0]};

  // Table read has no bypass: a same-cycle E write is seen by D only next cycle.
  assign pred_valid_D = valid_D & (br_type_D < 4'b1000);
  assign pred_taken_D = pred_valid_D & cnt_table[idx_D][1];

  assign raw_mispredict = br_valid_E & (pred_E ^ comp_result_E);
  assign train          = br_valid_E & ~stall & ~flush;

  // Outputs are forced quiet while reset is held, even before the reset edge.
  assign mispredict_E = raw_mispredict & ~rst;
  assign br_count     = rst ? 32'd0 : br_count_q;
  assign miss_count   = rst ? 32'd0 : miss_count_q;

  assign cur_cnt = cnt_table[idx_E];

  always_comb begin
    next_cnt = cur_cnt;
    if (comp_result_E) begin
      if (cur_cnt != 2'b11) next_cnt = cur_cnt + 2'd1;
    end else begin
      if (cur_cnt != 2'b00) next_cnt = cur_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_table[i] <= CNT_INIT;
      br_valid_E   <= 1'b0;
      pred_E       <= 1'b0;
      idx_E        <= '0;
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      if (flush) begin
        br_valid_E <= 1'b0;
      end else if (!stall) begin
        br_valid_E <= pred_valid_D;
        pred_E     <= pred_taken_D;
        idx_E      <= idx_D;
      end

      if (train) begin
        cnt_table[idx_E] <= next_cnt;
        if (br_count_q != 32'hFFFF_FFFF) br_count_q <= br_count_q + 32'd1;
        if (raw_mispredict && (miss_count_q != 32'hFFFF_FFFF))
          miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_dir_predictor.sv
// Directed self-checking bench for branch_dir_predictor; one stimulus vector per cycle,
// checks sampled mid-cycle against hand-computed values.
module tb_branch_dir_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_D;
  logic        valid_D;
  logic [3:0]  br_type_D;
  logic        stall;
  logic        flush;
  logic        comp_result_E;
  logic        pred_valid_D;
  logic        pred_taken_D;
  logic        mispredict_E;
  logic [31:0] br_count;
  logic [31:0] miss_count;

  int tests_run = 0;
  int tests_failed = 0;

  branch_dir_predictor #(.IDX_W(6), .CNT_INIT(2'b01)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_D          (pc_D),
    .valid_D       (valid_D),
    .br_type_D     (br_type_D),
    .stall         (stall),
    .flush         (flush),
    .comp_result_E (comp_result_E),
    .pred_valid_D  (pred_valid_D),
    .pred_taken_D  (pred_taken_D),
    .mispredict_E  (mispredict_E),
    .br_count      (br_count),
    .miss_count    (miss_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs settle before checks.
  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] bt,
                               input logic [31:0] pc, input logic s, input logic f,
                               input logic c);
    @(posedge clk);
    #1;
    rst = r; valid_D = v; br_type_D = bt; pc_D = pc;
    stall = s; flush = f; comp_result_E = c;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; valid_D = 1'b0; br_type_D = 4'h8; pc_D = '0;
    stall = 1'b0; flush = 1'b0; comp_result_E = 1'b0;

    // Reset held: outputs quiet
    applyStimulus(1, 0, 4'h8, 32'h0, 0, 0, 0);
    checkOutput("rst_mispredict", {31'd0, mispredict_E}, 32'd0);
    checkOutput("rst_br_count", br_count, 32'd0);
    checkOutput("rst_miss_count", miss_count, 32'd0);

    // Reset then lookup
    applyStimulus(0, 1, 4'h0, 32'h40, 0, 0, 0);
    checkOutput("beq_pred_valid", {31'd0, pred_valid_D}, 32'd1);
    checkOutput("beq_pred_taken", {31'd0, pred_taken_D}, 32'd0);
    checkOutput("post_rst_mispredict", {31'd0, mispredict_E}, 32'd0);
    applyStimulus(0, 1, 4'h8, 32'h44, 0, 1, 0);
    checkOutput("nonbr_pred_valid", {31'd0, pred_valid_D}, 32'd0);
    applyStimulus(0, 1, 4'hB, 32'h44, 0, 0, 0);
    checkOutput("type_b_pred_valid", {31'd0, pred_valid_D}, 32'd0);

    // Training to taken: BNE @0x100 (index 0), resolved taken three times
    applyStimulus(0, 1, 4'h1, 32'h100, 0, 0, 0);
    checkOutput("bne1_pred", {31'd0, pred_taken_D}, 32'd0);
    applyStimulus(0, 0, 4'h8, 32'h0, 0, 0, 1);
    checkOutput("bne1_mispredict", {31'd0, mispredict_E}, 32'd1);
    applyStimulus(0, 1, 4'h1, 32'h100, 0, 0, 0);
    checkOutput("bne2_pred", {31'd0, pred_taken_D}, 32'd1);
    applyStimulus(0, 0, 4'h8, 32'h0, 0, 0, 1);
    checkOutput("bne2_mispredict", {31'd0, mispredict_E}, 32'd0);
    applyStimulus(0, 1, 4'h1, 32'h100, 0, 0, 0);
    checkOutput("bne3_pred", {31'd0, pred_taken_D}, 32'd1);
    applyStimulus(0, 0, 4'h8, 32'h0, 0, 0, 1);
    checkOutput("bne3_mispredict", {31'd0, mispredict_E}, 32'd0);
    applyStimulus(0, 1, 4'h1, 32'h100, 0, 0, 0);
    checkOutput("bne4_pred", {31'd0, pred_taken_D}, 32'd1);
    checkOutput("train_br_count", br_count, 32'd3);
    checkOutput("train_miss_count", miss_count, 32'd1);

    // Hysteresis: counter 11, one not-taken -> 10, still predicts taken
    applyStimulus(0, 0, 4'h8, 32'h0, 0, 0, 0);
    checkOutput("hyst_mispredict", {31'd0, mispredict_E}, 32'd1);
    applyStimulus(0, 1, 4'h1, 32'h100, 0, 0, 0);
    checkOutput("hyst_pred", {31'd0, pred_taken_D}, 32'd1);
    checkOutput("hyst_br_count", br_count, 32'd4);

    // Stall in E for three cycles: no training, mispredict steady
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 4'h1, 32'h100, 1, 0, 0);
      checkOutput("stall_mispredict", {31'd0, mispredict_E}, 32'd1);
      checkOutput("stall_pred", {31'd0, pred_taken_D}, 32'd1);
      checkOutput("stall_br_count", br_count, 32'd4);
    end
    applyStimulus(0, 0, 4'h8, 32'h0, 0, 0, 0);
    checkOutput("unstall_mispredict", {31'd0, mispredict_E}, 32'd1);
    applyStimulus(0, 1, 4'h1, 32'h100, 0, 0, 0);
    checkOutput("unstall_pred", {31'd0, pred_taken_D}, 32'd0);
    checkOutput("unstall_br_count", br_count, 32'd5);
    checkOutput("unstall_miss_count", miss_count, 32'd3);

    // Flush a mispredicting E branch: no training, mispredict drops
    applyStimulus(0, 0, 4'h8, 32'h0, 0, 1, 1);
    checkOutput("flush_mispredict_now", {31'd0, mispredict_E}, 32'd1);
    applyStimulus(0, 1, 4'h1, 32'h100, 0, 0, 1);
    checkOutput("flush_mispredict_next", {31'd0, mispredict_E}, 32'd0);
    checkOutput("flush_br_count", br_count, 32'd5);
    checkOutput("flush_pred", {31'd0, pred_taken_D}, 32'd0);

    // Same-cycle hazard on index 5 (pc 0x14)
    applyStimulus(0, 1, 4'h0, 32'h14, 0, 0, 0);
    checkOutput("idx5_pred_a", {31'd0, pred_taken_D}, 32'd0);
    applyStimulus(0, 1, 4'h0, 32'h14, 0, 0, 1);
    checkOutput("hazard_mispredict", {31'd0, mispredict_E}, 32'd1);
    checkOutput("hazard_old_value", {31'd0, pred_taken_D}, 32'd0);
    applyStimulus(0, 1, 4'h0, 32'h14, 0, 0, 1);
    checkOutput("hazard_new_value", {31'd0, pred_taken_D}, 32'd1);
    checkOutput("hazard_mispredict2", {31'd0, mispredict_E}, 32'd1);
    applyStimulus(0, 0, 4'h8, 32'h0, 0, 0, 1);
    checkOutput("idx5_mispredict3", {31'd0, mispredict_E}, 32'd0);
    applyStimulus(0, 0, 4'h8, 32'h0, 0, 0, 0);
    checkOutput("mid_br_count", br_count, 32'd9);
    checkOutput("mid_miss_count", miss_count, 32'd5);

    // Statistic saturation via backdoor
    force dut.br_count_q = 32'hFFFF_FFFF;
    force dut.miss_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_count_q;
    release dut.miss_count_q;
    applyStimulus(0, 1, 4'h0, 32'h14, 0, 0, 0);
    checkOutput("sat_pred", {31'd0, pred_taken_D}, 32'd1);
    applyStimulus(0, 0, 4'h8, 32'h0, 0, 0, 0);
    checkOutput("sat_mispredict", {31'd0, mispredict_E}, 32'd1);
    applyStimulus(0, 0, 4'h8, 32'h0, 0, 0, 0);
    checkOutput("sat_br_count", br_count, 32'hFFFF_FFFF);
    checkOutput("sat_miss_count", miss_count, 32'hFFFF_FFFF);

    // Reset asserted mid-stall wins; table returns to weakly not-taken
    applyStimulus(0, 1, 4'h0, 32'h14, 0, 0, 0);
    applyStimulus(1, 0, 4'h8, 32'h0, 1, 0, 0);
    checkOutput("rst_stall_mispredict", {31'd0, mispredict_E}, 32'd0);
    checkOutput("rst_stall_br_count", br_count, 32'd0);
    applyStimulus(0, 1, 4'h0, 32'h14, 0, 0, 0);
    checkOutput("rst_stall_pred", {31'd0, pred_taken_D}, 32'd0);
    checkOutput("rst_stall_mispredict2", {31'd0, mispredict_E}, 32'd0);
    checkOutput("rst_stall_miss_count", miss_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_dir_predictor.md
# branch_dir_predictor

Dynamic branch-direction predictor for the five-stage MIPS32 pipeline. It consumes the decode-stage branch-type code `br_type_D` and the PC, and returns a taken/not-taken prediction in the same D cycle. It then carries that prediction into E, compares it with the resolved comparator outcome, and raises a mispredict pulse. On the same edge it trains a table of 2-bit saturating counters, and it keeps branch and mispredict statistics for the performance counters.

## Interface
- `IDX_W`, 6, index width; the table holds 2^IDX_W counters, indexed by `pc_D[IDX_W+1:2]`.
- `CNT_INIT`, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_D` in 32: PC of the instruction in D.
- `valid_D` in 1: D holds a real instruction, not a bubble.
- `br_type_D` in 4: 0000 BEQ, 0001 BNE, 0010 BGEZ, 0011 BGTZ, 0100 BLEZ, 0101 BLTZ, 0110 BGEZAL, 0111 BLTZAL, 1000 not a branch. Values 1001–1111 are treated as 1000.
- `stall` in 1: pipeline stall. The D→E register and all training hold.
- `flush` in 1: kills the E-stage branch entry.
- `comp_result_E` in 1: resolved branch condition for the instruction in E (1 = taken).
- `pred_valid_D` out 1: `valid_D` and `br_type_D` < 4'b1000.
- `pred_taken_D` out 1: `pred_valid_D` and bit[1] of the indexed counter.
- `mispredict_E` out 1: an E-stage branch whose prediction differs from `comp_result_E`.
- `br_count` out 32: number of resolved branches, saturating.
- `miss_count` out 32: number of resolved mispredicts, saturating.

## Operation
- **Table:** 2^IDX_W entries of 2-bit counters, held in flops. The D-stage read is asynchronous, with no write bypass: a D read in the same cycle as an E write to the same index returns the old value.
- **Counter semantics:** 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
- **D→E register** (fields `br_valid_E`, `pred_E`, `idx_E`):
  - `rst` or `flush` → `br_valid_E` = 0.
  - Else, if `!stall` → load `pred_valid_D`, `pred_taken_D`, `pc_D[IDX_W+1:2]`.
  - Else → hold.
  - `flush` has priority over `stall`.
- **Resolution:** `mispredict_E` = `br_valid_E & (pred_E ^ comp_result_E)`. It is combinational from the E register and `comp_result_E`.
- **Training:** only when `br_valid_E & !stall & !flush` does the table write `table[idx_E]` with the counter moved toward `comp_result_E`. A stalled E branch trains exactly once, on the cycle the stall drops.
- **Statistics:** on each training event `br_count` increments. `miss_count` also increments when `mispredict_E` is high. Both counters saturate at 32'hFFFF_FFFF and never wrap.
- **Reset:** every table entry is set to `CNT_INIT`; `br_valid_E`, `pred_E`, `idx_E`, `br_count` and `miss_count` are set to 0. All of this completes in one cycle. If reset is asserted mid-stall, reset wins.

## Timing
- **Prediction latency:** 0 cycles; `pred_taken_D` is valid in the same cycle as `pc_D`/`br_type_D`.
- **Mispredict timing:** exactly one cycle after the D cycle in which the branch advanced, with no stall in between.
- **Training visibility:** the update from E in cycle n is visible to a D lookup in cycle n+1. It is not visible in cycle n.
- **Reset values:** one cycle after `rst` is released, all outputs are 0 except where they follow the inputs. `pred_taken_D` = 0 for every PC, because `CNT_INIT` bit[1] is 0.
- **Outputs during `rst`:** `mispredict_E` = 0 and the counters read 0.

## Test plan
- **Reset then lookup:** assert `rst` 1 cycle, then present BEQ at `pc_D`=0x0000_0040 → `pred_valid_D`=1, `pred_taken_D`=0. A D lookup of 0x0000_0044 with `br_type_D`=1000 → `pred_valid_D`=0.
- **Training to taken:** issue BNE at 0x100 three times with `comp_result_E`=1.
  - `mispredict_E` pattern is 1, 0, 0 (the counter reaches 10 after the first training, 11 after the second).
  - A 4th lookup gives `pred_taken_D`=1.
  - `br_count`=3, `miss_count`=1.
- **Saturation and hysteresis:** from counter 11, one not-taken resolution → `mispredict_E`=1 and the counter becomes 10. The next lookup still gives `pred_taken_D`=1.
- **Stall in E:** branch in E with `stall`=1 for 3 cycles → table and `br_count` are unchanged during the stall. Exactly one update happens on release, and `mispredict_E` is held steady throughout.
- **Flush and same-cycle hazard:**
  - `flush` with a mispredicting branch in E → no training and `br_count` unchanged; `mispredict_E` goes to 0 the next cycle.
  - Separately, E trains index 5 while D looks up index 5 in the same cycle → D sees the pre-update value.
- **Counter saturation:** force `br_count`=`miss_count`=32'hFFFF_FFFF (via backdoor), then resolve a mispredict → both stay at 32'hFFFF_FFFF.
